mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the EX/MEM pipeline register and the word-wide data memory. It accepts one byte-addressed load or store at a time, handles byte, halfword and word accesses, and sign- or zero-extends load data. Sub-word stores use a read-modify-write sequence because the data memory has no byte enables. It stalls the pipeline while a request is in flight and presents formatted load data to the MEM/WB register.

## Interface
- NB_DATA, 32, data word width; only 32 is supported
- NB_WADDR, 7, data-memory word-address width (128 words, 512 bytes)

- clock_i  in  1  system clock; all state changes on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- valid_i  in  1  request present from EX/MEM
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- mem_read_i  in  1  load request
- mem_write_i  in  1  store request
- size_i  in  2  00 byte, 01 half, 10 word; 11 illegal
- unsigned_i  in  1  load zero-extends when 1
- mem_enable_o  out  1  data-memory enable
- mem_addr_o  out  NB_WADDR  word address, equal to latched addr[8:2]
- mem_wdata_o  out  32  data-memory write data
- mem_read_o / mem_write_o  out  1 each  data-memory read / write strobes
- mem_rdata_i  in  32  data-memory read data; registered, valid the cycle after the read strobe
- stall_o  out  1  upstream must hold and must not present a new request
- load_data_o  out  32  formatted load result
- load_valid_o  out  1  one-cycle pulse when load_data_o is new
- fault_o  out  1  one-cycle pulse for a rejected request

## Operation
- States: IDLE, LD_ISSUE, LD_DATA, ST_WRITE, RMW_READ, RMW_WRITE. State is encoded in registers.
- A request is accepted only in IDLE with valid_i=1. On acceptance the unit latches addr, wdata, size and unsigned.
- Rejection: the request is dropped, no memory access occurs, fault_o pulses next cycle and the state stays IDLE. Causes:
  - mem_read_i and mem_write_i both 1
  - size_i = 11
  - half access with addr[0]=1
  - word access with addr[1:0]≠0
- valid_i=1 with neither mem_read_i nor mem_write_i set is ignored silently.
- addr_i[31:9] is ignored, so addresses wrap modulo 512 bytes.
- Load: IDLE→LD_ISSUE→LD_DATA→IDLE.
  - LD_ISSUE drives mem_enable_o=1 and mem_read_o=1.
  - In LD_DATA, mem_rdata_i is lane-selected and extended, then registered into load_data_o.
- Lanes are little-endian: byte n occupies bits [8n+7:8n].
  - Byte loads select lane addr[1:0].
  - Half loads select lane pair addr[1].
  - Results are sign-extended unless unsigned_i=1. Word loads are passed through unchanged.
- Word store: IDLE→ST_WRITE→IDLE. ST_WRITE drives mem_enable_o=1, mem_write_o=1 and mem_wdata_o=latched wdata.
- Sub-word store: IDLE→RMW_READ→RMW_WRITE→IDLE.
  - RMW_READ drives enable and read.
  - RMW_WRITE drives enable and write. mem_wdata_o is mem_rdata_i with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. This merge is combinational.
- In IDLE all memory strobes and mem_enable_o are 0, and mem_addr_o holds its last value.
- stall_o = (state ≠ IDLE).

## Timing
- Reset values while reset_n_i=0, applied asynchronously:
  - state IDLE
  - stall_o, load_valid_o, fault_o, mem_enable_o, mem_read_o, mem_write_o all 0
  - load_data_o, mem_addr_o, mem_wdata_o all 0
- Reset mid-operation aborts the sequence. A write whose strobe cycle has not completed a posedge is not performed.
- Load, accepted in cycle 0:
  - strobes in cycle 1
  - data sampled in cycle 2
  - load_valid_o=1 in cycle 3; stall_o=1 in cycles 1–2
  - the next request can be accepted in cycle 3
- Word store: write strobe in cycle 1, stall_o=1 in cycle 1, next accept in cycle 2.
- Sub-word store: read in cycle 1, merged write in cycle 2, stall_o=1 in cycles 1–2, next accept in cycle 3.
- Fault: fault_o=1 in cycle 1, stall_o stays 0, and a new request can be accepted in cycle 1.
- load_data_o holds its value until the next load completes. Stores and faults do not alter it.
- Back-to-back: a load accepted in the cycle where load_valid_o pulses proceeds normally.

## Test plan
- Memory word 1 = 0x80F003FF; load byte, addr 0x07, signed → load_valid_o in cycle 3, load_data_o=0xFFFFFF80. Repeat with unsigned → 0x00000080.
- Word 1 = 0x80F003FF; load half, addr 0x04, signed → 0x000003FF. Addr 0x06, signed → 0xFFFF80F0.
- Word 2 = 0x11223344; store byte 0xAA at addr 0x09 → stall_o=1 for 2 cycles, then word 2 = 0x1122AA44. Loading word addr 0x08 then returns 0x1122AA44.
- Store word 0xDEADBEEF at addr 0x0C, then immediately load word addr 0x0C → store stalls 1 cycle; load returns 0xDEADBEEF with no gap between the store and the load acceptance.
- Requests with no memory strobe in any cycle:
  - load word at addr 0x02 → fault_o=1 in cycle 1
  - half at addr 0x05 → fault_o=1 in cycle 1
  - read and write both set → fault_o=1
- Sub-word store at addr 0x09, with reset_n_i pulsed low during RMW_READ → outputs zero immediately, state IDLE; word 2 unchanged, with no write strobe issued.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between EX/MEM and a word-wide data memory without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module mem_access_unit #(
  parameter int NB_DATA  = 32,
  parameter int NB_WADDR = 7
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                valid_i,
  input  logic [31:0]         addr_i,
  input  logic [NB_DATA-1:0]  wdata_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  output logic                mem_enable_o,
  output logic [NB_WADDR-1:0] mem_addr_o,
  output logic [NB_DATA-1:0]  mem_wdata_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  input  logic [NB_DATA-1:0]  mem_rdata_i,
  output logic                stall_o,
  output logic [NB_DATA-1:0]  load_data_o,
  output logic                load_valid_o,
  output logic                fault_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_ISSUE  = 3'd1,
    LD_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    RMW_READ  = 3'd4,
    RMW_WRITE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [NB_WADDR-1:0]  addr_q, addr_d;
  logic [1:0]           lane_q, lane_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [NB_DATA-1:0]   wdata_q, wdata_d;
  logic [NB_DATA-1:0]   load_data_q, load_data_d;
  logic                 load_valid_q, load_valid_d;
  logic                 fault_q, fault_d;
  logic                 en_q, en_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 stall_q, stall_d;

  logic                 req_bad_s;
  logic [7:0]           byte_s;
  logic [15:0]          half_s;
  logic [NB_DATA-1:0]   ext_s;
  logic [NB_DATA-1:0]   merged_s;
  logic                 unused_addr_s;

  // Upper address bits wrap away: the memory is only 512 bytes.
  assign unused_addr_s = ^addr_i[31:9];

  // Illegal request detection: conflicting strobes, bad size, misalignment.
  always_comb begin
    req_bad_s = 1'b0;
    if (mem_read_i && mem_write_i) begin
      req_bad_s = 1'b1;
    end else begin
      case (size_i)
        2'b00:   req_bad_s = 1'b0;
        2'b01:   req_bad_s = addr_i[0];
        2'b10:   req_bad_s = (addr_i[1:0] != 2'b00);
        default: req_bad_s = 1'b1;
      endcase
    end
  end

  // Load lane select and extension, plus the store lane merge into read data.
  always_comb begin
    byte_s   = mem_rdata_i[{lane_q, 3'b000} +: 8];
    half_s   = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ext_s    = mem_rdata_i;
    merged_s = mem_rdata_i;
    case (size_q)
      2'b00: begin
        ext_s = uns_q ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
        merged_s[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        ext_s = uns_q ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
        if (lane_q[1]) begin
          merged_s[31:16] = wdata_q[15:0];
        end else begin
          merged_s[15:0] = wdata_q[15:0];
        end
      end
      default: begin
        ext_s    = mem_rdata_i;
        merged_s = wdata_q;
      end
    endcase
  end

  // Sequencer next state; strobes and stall are derived from the next state so they register cleanly.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && (mem_read_i || mem_write_i)) begin
          if (req_bad_s) begin
            fault_d = 1'b1;
          end else begin
            addr_d  = addr_i[8:2];
            lane_d  = addr_i[1:0];
            size_d  = size_i;
            uns_d   = unsigned_i;
            wdata_d = wdata_i;
            if (mem_read_i) begin
              state_d = LD_ISSUE;
            end else if (size_i == 2'b10) begin
              state_d = ST_WRITE;
            end else begin
              state_d = RMW_READ;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      LD_ISSUE:  state_d = LD_DATA;
      LD_DATA: begin
        load_data_d  = ext_s;
        load_valid_d = 1'b1;
        state_d      = IDLE;
      end
      ST_WRITE:  state_d = IDLE;
      RMW_READ:  state_d = RMW_WRITE;
      RMW_WRITE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    rd_d    = (state_d == LD_ISSUE) || (state_d == RMW_READ);
    wr_d    = (state_d == ST_WRITE) || (state_d == RMW_WRITE);
    en_d    = rd_d || wr_d;
    stall_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lane_q       <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      en_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
      en_q         <= en_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      stall_q      <= stall_d;
    end
  end

  assign mem_enable_o = en_q;
  assign mem_read_o   = rd_q;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = (state_q == RMW_WRITE) ? merged_s : wdata_q;
  assign stall_o      = stall_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a registered-read memory model and a load scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic        mem_en, mem_rd, mem_wr;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall, load_valid, fault;
  logic [31:0] load_data;

  logic [31:0] mem [0:127];
  logic        poke_en = 1'b0;
  logic [6:0]  poke_addr = 7'd0;
  logic [31:0] poke_data = 32'h0;

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_strobes = 0;
  int          any_strobes = 0;
  logic [31:0] sb_q [$];
  logic [31:0] held;
  int          wr_before, any_before;

  mem_access_unit #(.NB_DATA(32), .NB_WADDR(7)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .valid_i(valid), .addr_i(addr), .wdata_i(wdata),
    .mem_read_i(rd), .mem_write_i(wr), .size_i(size), .unsigned_i(uns),
    .mem_enable_o(mem_en), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_rd), .mem_write_o(mem_wr), .mem_rdata_i(mem_rdata),
    .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid), .fault_o(fault)
  );

  always #5 clk = ~clk;

  // Data memory model: registered read, synchronous write, plus a bench-side poke port.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_en && mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_en && mem_wr) wr_strobes <= wr_strobes + 1;
    if (mem_en) any_strobes <= any_strobes + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every load_valid pulse retires the oldest expected load result.
  always @(negedge clk) begin
    if (rst_n && load_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_load", load_data, 32'hXXXXXXXX);
      end else begin
        chk("sb_load_data", load_data, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [6:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  // Presents one request for one cycle; returns in cycle 1 relative to acceptance.
  task automatic req(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] s, input logic u);
    valid = 1'b1; rd = r; wr = w; addr = a; wdata = d; size = s; uns = u;
    tick();
    valid = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] exp);
    sb_q.push_back(exp);
    req(1'b1, 1'b0, a, 32'h0, s, u);
    chk("ld_c1_stall", {31'b0, stall}, 32'd1);
    chk("ld_c1_read", {29'b0, mem_en, mem_rd, mem_wr}, 32'd6);
    chk("ld_c1_addr", {25'b0, mem_addr}, {25'b0, a[8:2]});
    tick();
    chk("ld_c2_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("ld_c3_valid", {30'b0, load_valid, stall}, 32'd2);
  endtask

  initial begin
    #2;
    chk("rst_ctrl", {26'b0, stall, load_valid, fault, mem_en, mem_rd, mem_wr}, 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_addr", {25'b0, mem_addr}, 32'h0);
    tick();
    poke(7'd1, 32'h80F003FF);
    poke(7'd2, 32'h11223344);
    poke(7'd3, 32'h00000000);
    rst_n = 1'b1;
    tick();

    load(32'h07, 2'b00, 1'b0, 32'hFFFFFF80);
    load(32'h07, 2'b00, 1'b1, 32'h00000080);
    load(32'h04, 2'b01, 1'b0, 32'h000003FF);
    load(32'h06, 2'b01, 1'b0, 32'hFFFF80F0);
    load(32'h06, 2'b01, 1'b1, 32'h000080F0);
    load(32'h205, 2'b00, 1'b0, 32'h00000003);

    // Sub-word RMW store.
    held = load_data;
    req(1'b0, 1'b1, 32'h09, 32'h000000AA, 2'b00, 1'b0);
    chk("rmw_c1_stall", {31'b0, stall}, 32'd1);
    chk("rmw_c1_strobe", {29'b0, mem_en, mem_rd, mem_wr}, 32'd6);
    tick();
    chk("rmw_c2_strobe", {29'b0, mem_en, mem_rd, mem_wr, stall}, 32'd11);
    chk("rmw_c2_wdata", mem_wdata, 32'h1122AA44);
    tick();
    chk("rmw_c3_stall", {31'b0, stall}, 32'd0);
    chk("rmw_mem2", mem[2], 32'h1122AA44);
    chk("store_keeps_load_data", load_data, held);
    load(32'h08, 2'b10, 1'b0, 32'h1122AA44);

    // Word store followed immediately by load.
    req(1'b0, 1'b1, 32'h0C, 32'hDEADBEEF, 2'b10, 1'b0);
    chk("sw_c1", {28'b0, mem_en, mem_rd, mem_wr, stall}, 32'd11);
    chk("sw_c1_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("sw_c2_stall", {31'b0, stall}, 32'd0);
    load(32'h0C, 2'b10, 1'b0, 32'hDEADBEEF);

    // Rejected and ignored requests.
    held = load_data;
    any_before = any_strobes;
    req(1'b1, 1'b0, 32'h02, 32'h0, 2'b10, 1'b0);
    chk("flt_word_c1", {29'b0, fault, stall, mem_en}, 32'd4);
    req(1'b1, 1'b0, 32'h05, 32'h0, 2'b01, 1'b0);
    chk("flt_half_c1", {29'b0, fault, stall, mem_en}, 32'd4);
    req(1'b1, 1'b1, 32'h08, 32'h0, 2'b10, 1'b0);
    chk("flt_rw_c1", {29'b0, fault, stall, mem_en}, 32'd4);
    req(1'b0, 1'b1, 32'h08, 32'h0, 2'b11, 1'b0);
    chk("flt_size_c1", {29'b0, fault, stall, mem_en}, 32'd4);
    req(1'b0, 1'b0, 32'h08, 32'h0, 2'b10, 1'b0);
    chk("ignored_c1", {29'b0, fault, stall, mem_en}, 32'd0);
    tick();
    chk("flt_no_strobes", any_strobes, any_before);
    chk("flt_keeps_load_data", load_data, held);

    // Reset during RMW_READ aborts the store.
    wr_before = wr_strobes;
    req(1'b0, 1'b1, 32'h09, 32'h00000055, 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {26'b0, stall, load_valid, fault, mem_en, mem_rd, mem_wr}, 32'd0);
    chk("arst_load_data", load_data, 32'h0);
    chk("arst_mem_addr", {25'b0, mem_addr}, 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst_idle", {31'b0, stall}, 32'd0);
    chk("arst_no_write", wr_strobes, wr_before);
    chk("arst_mem2", mem[2], 32'h1122AA44);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
